// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner.
package seg_disp_pkg;

  localparam int unsigned DIGIT_W = 3;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg_display_scanner_seg7.sv
// 3-bit value to seven-segment pattern decoder (active-high segments).
module seven_segment_cntrl (
  input  logic [2:0] inp,
  output logic       seg_a,
  output logic       seg_b,
  output logic       seg_c,
  output logic       seg_d,
  output logic       seg_e,
  output logic       seg_f,
  output logic       seg_g
);

  logic [6:0] pattern;

  // Segment pattern lookup, ordered {a,b,c,d,e,f,g}.
  always_comb begin
    pattern = 7'b0000000;
    case (inp)
      3'd0: pattern = 7'b1111110;
      3'd1: pattern = 7'b0110000;
      3'd2: pattern = 7'b1101101;
      3'd3: pattern = 7'b1111001;
      3'd4: pattern = 7'b0110011;
      3'd5: pattern = 7'b1011011;
      3'd6: pattern = 7'b1011111;
      3'd7: pattern = 7'b1110000;
      default: pattern = 7'b0000000;
    endcase
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = pattern;

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed digit scanner with blanking guard and frame-aligned,
// double-buffered display updates.
module seg_display_scanner
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
  output logic                          load_ack,
  output logic                          frame_tick,
  output logic [NUM_DIGITS-1:0]         dig_en,
  output logic                          seg_a,
  output logic                          seg_b,
  output logic                          seg_c,
  output logic                          seg_d,
  output logic                          seg_e,
  output logic                          seg_f,
  output logic                          seg_g
);

  localparam int unsigned CNT_W  = clog2(PRESCALE);
  localparam int unsigned IDX_W  = clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = DIGIT_W * NUM_DIGITS;

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       active_q, active_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [DIGIT_W-1:0]      digit_val_q, digit_val_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    load_ack_q, load_ack_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    slot_end;
  logic                    last_slot;
  logic                    boundary;

  // Next-state logic: slot timing, digit fetch and load handshake.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    digit_val_d  = digit_val_q;
    load_ack_d   = 1'b0;
    frame_tick_d = 1'b0;
    dig_en_d     = '0;

    slot_end  = (pcnt_q == CNT_W'(PRESCALE - 1));
    last_slot = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary  = en && (state_q == ST_SHOW) && slot_end && last_slot;

    if (en) begin
      if (pcnt_q == '0) begin
        digit_val_d = active_q[DIGIT_W*int'(idx_q) +: DIGIT_W];
      end
      pcnt_d = pcnt_q + CNT_W'(1);
      case (state_q)
        ST_BLANK: begin
          if (pcnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (slot_end) begin
            state_d = ST_BLANK;
            pcnt_d  = '0;
            idx_d   = last_slot ? '0 : idx_q + IDX_W'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // A load on the boundary itself bypasses the shadow buffer.
    if (boundary) begin
      frame_tick_d = 1'b1;
      if (load) begin
        active_d   = data_in;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (pending_q) begin
        active_d   = shadow_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end

    if (state_d == ST_SHOW) begin
      dig_en_d = NUM_DIGITS'(1) << idx_d;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      pcnt_q       <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      digit_val_q  <= '0;
      dig_en_q     <= '0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      digit_val_q  <= digit_val_d;
      dig_en_q     <= dig_en_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Scanning disabled blanks every digit immediately.
  assign dig_en     = en ? dig_en_q : '0;
  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;

  seven_segment_cntrl u_seg7 (
    .inp   (digit_val_q),
    .seg_a (seg_a),
    .seg_b (seg_b),
    .seg_c (seg_c),
    .seg_d (seg_d),
    .seg_e (seg_e),
    .seg_f (seg_f),
    .seg_g (seg_g)
  );

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner (4 digits, 8-cycle slots, 2 blank).
module tb_seg_display_scanner;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [11:0] data_in;
  logic        load_ack;
  logic        frame_tick;
  logic [3:0]  dig_en;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [6:0]  segs;

  int errors;
  int checks;
  int ec;
  int phase;
  logic last_en;

  assign segs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  seg_display_scanner #(
    .NUM_DIGITS   (4),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .dig_en     (dig_en),
    .seg_a      (seg_a),
    .seg_b      (seg_b),
    .seg_c      (seg_c),
    .seg_d      (seg_d),
    .seg_e      (seg_e),
    .seg_f      (seg_f),
    .seg_g      (seg_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written segment table, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      default: return 7'b1110000;
    endcase
  endfunction

  // Value digit k should show during frame fr of the current phase.
  function automatic int exp_digit(input int fr, input int k);
    if (phase != 1) return 0;
    case (fr)
      0: return 0;
      1: return 3 - k;
      2: begin
        case (k)
          0: return 3;
          1: return 1;
          2: return 5;
          default: return 6;
        endcase
      end
      3: return 5;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at ec=%0d phase=%0d: observed=%0h expected=%0h", tag, ec, phase, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int pc, slot, fr;
    logic [3:0] ed;
    logic et, ea;
    pc   = ec % 8;
    slot = (ec / 8) % 4;
    fr   = ec / 32;
    ed   = (en && pc >= 2) ? 4'(1 << slot) : 4'b0000;
    et   = last_en && (ec > 0) && (ec % 32 == 0);
    ea   = et && (phase == 1) && (fr >= 1) && (fr <= 4);
    check("dig_en", 32'(dig_en), 32'(ed));
    check("frame_tick", 32'(frame_tick), 32'(et));
    check("load_ack", 32'(load_ack), 32'(ea));
    if (ed != 4'b0000) begin
      check("seg", 32'(segs), 32'(seg_of(exp_digit(fr, slot))));
    end
  endtask

  task automatic tick();
    logic en_prev;
    en_prev = en;
    @(posedge clk);
    #1;
    if (en_prev) ec++;
    last_en = en_prev;
    check_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dig_en"}, 32'(dig_en), 32'h0);
    check({tag, "_load_ack"}, 32'(load_ack), 32'h0);
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
    check({tag, "_seg"}, 32'(segs), 32'(seg_of(0)));
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    ec      = 0;
    phase   = 0;
    last_en = 1'b0;
    rst     = 1'b1;
    en      = 1'b1;
    load    = 1'b0;
    data_in = 12'h000;

    // Bring-up, then let the scanner run into a SHOW slot.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);

    // Async reset asserted between edges clears outputs at once.
    #4 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    rst = 1'b0;

    // Cycle 0: first load ({0,1,2,3} for digits 3..0).
    phase   = 1;
    ec      = 0;
    last_en = 1'b0;
    load    = 1'b1;
    data_in = {3'd0, 3'd1, 3'd2, 3'd3};
    check_cycle();

    while (ec < 130) begin
      tick();
      load = 1'b0;
      case (ec)
        40:  begin load = 1'b1; data_in = {3'd6, 3'd5, 3'd1, 3'd3}; end
        70:  begin load = 1'b1; data_in = {4{3'd1}}; end
        80:  begin load = 1'b1; data_in = {4{3'd5}}; end
        127: begin load = 1'b1; data_in = {4{3'd2}}; end
        default: ;
      endcase
    end

    // Freeze scanning for 20 cycles in slot 0 SHOW.
    en = 1'b0;
    #1 check_cycle();
    repeat (20) tick();
    en = 1'b1;
    #1 check_cycle();

    while (ec < 135) tick();
    load    = 1'b1;
    data_in = {4{3'd7}};
    tick();
    load = 1'b0;
    while (ec < 140) tick();

    // Reset mid-SHOW with a load pending; the load must be discarded.
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    phase   = 2;
    ec      = 0;
    last_en = 1'b0;
    check_cycle();
    repeat (45) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexed display controller for the multiplier result display.
- Shares a single seven_segment_cntrl decoder between NUM_DIGITS 3-bit digit values and drives one-hot digit enables with a per-slot blanking guard against ghosting.
- New display values arrive through a load/ack handshake and are double-buffered, so they are applied only at frame boundaries (no tearing).
- Sits between the multiplier result/step logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- PRESCALE, 1000, clock cycles per digit slot (> BLANK_CYCLES).
- BLANK_CYCLES, 2, cycles at the start of each slot with all digit enables off (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  scan enable; low freezes scanning and blanks the display.
- load  in  1  one-cycle request to capture data_in.
- data_in  in  3*NUM_DIGITS  digit values; digit k = data_in[3k+2:3k]; digit 0 is scanned first.
- load_ack  out  1  one-cycle pulse when captured data becomes active.
- frame_tick  out  1  one-cycle pulse at each frame wrap.
- dig_en  out  NUM_DIGITS  one-hot active-high digit enable.
- seg_a..seg_g  out  1 each  segment outputs of the internal seven_segment_cntrl.

Behaviour:
- Reset (async, immediate): state=BLANK, slot index idx=0, prescale counter pcnt=0, active register=0, shadow register=0, pending=0, digit_val=0, dig_en=0, load_ack=0, frame_tick=0. seg_* then show the decoder output for 3'b000.
- Datapath: seg_* come combinationally from seven_segment_cntrl with inp=digit_val. digit_val is a register loaded from the active-register slice idx on the first cycle of each slot.
- FSM (advances only while en=1):
  - BLANK: dig_en=0. Leave when pcnt==BLANK_CYCLES-1, going to SHOW.
  - SHOW: dig_en=1<<idx. When pcnt==PRESCALE-1, go to BLANK, set pcnt=0 and idx=idx+1.
  - pcnt increments every enabled cycle; it is not reset on entering SHOW. A slot is therefore exactly PRESCALE cycles long.
  - Frame boundary: the last cycle of slot idx==NUM_DIGITS-1. On it, idx wraps to 0 and frame_tick is asserted (registered) for the following cycle.
- Load handshake:
  - load=1 copies data_in into the shadow register and sets pending. It is always accepted, with no busy signal.
  - A later load before the boundary overwrites shadow; last write wins, and only one ack is issued.
  - At a frame boundary with pending=1: active<=shadow, pending<=0, and load_ack pulses on the same cycle as frame_tick.
  - load on the boundary cycle itself: data_in goes straight to active, pending stays 0, and load_ack pulses with that frame_tick.
  - load while en=0: data is captured into shadow; transfer waits for the next boundary after scanning resumes.
- en=0: dig_en forced to 0 combinationally. pcnt, idx and state hold; no frame_tick or load_ack is generated.
- Reset mid-frame or mid-load: all state cleared and a pending load is discarded. After release, scanning restarts at slot 0 in BLANK.
- No output ever has more than one dig_en bit high.

Decomposition:
- Shared package seg_disp_pkg:
  - state encoding constants ST_BLANK, ST_SHOW.
  - DIGIT_W=3.
  - counter width function clog2 for PRESCALE and NUM_DIGITS.
- One sub-module: the existing seven_segment_cntrl, instantiated once with inp=digit_val. Scan FSM, counters and buffers stay in the top.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, en=1 unless stated):
1. Assert rst for 3 cycles, with rst rising between clock edges -> dig_en=0000, load_ack=0, frame_tick=0 immediately. seg_* equal the decoder output for 3'b000.
2. After reset release, load with data_in={3'd0,3'd1,3'd2,3'd3} (digit3..0) at cycle 0 -> dig_en follows:
   - cycles 0-1: 0000; cycles 2-7: 0001.
   - cycles 8-9: 0000; cycles 10-15: 0010.
   - ... through cycles 26-31: 1000.
   - frame_tick and load_ack both high at cycle 32 only.
   - From cycle 32, digit k shows value 3-k on its slot (decoder outputs for 3,2,1,0).
3. Mid-frame (cycle 40), load data_in={3'd6,3'd5,3'd1,3'd3} -> the frame in progress still shows 3,2,1,0. load_ack and frame_tick pulse at cycle 64; the frame starting at cycle 64 shows 3,1,5,6 for digits 0..3.
4. Two loads in the same frame (cycles 70 and 80: all 3'd1, then all 3'd5) -> exactly one load_ack, at cycle 96; all digits show 5, and 1 is never displayed.
5. Load with all digits 3'd2 exactly on the boundary cycle (cycle 127) -> load_ack pulses at cycle 128 and the frame from cycle 128 shows all 2s. Then drive en=0 for 20 cycles -> dig_en=0000, no frame_tick, counters hold, and scanning resumes from the same slot/pcnt when en returns to 1.
6. Issue a load at cycle 135, then assert rst at cycle 140 (slot 1 SHOW) -> outputs go to reset values at once and no load_ack follows. After release, dig_en=0001 first appears 2 cycles later, and all digits display 0.
